im_axi_read_slave: RTL

IM_AXI_READ_SLAVE -- requirements
Module: im_axi_read_slave

---
 rtl/im_axi_read_slave_pkg.sv | 42 ++++
 rtl/im_axi_read_slave_burst_addr_gen.sv | 25 ++
 rtl/im_axi_read_slave.sv | 136 +++++++++++++
 3 files changed

// File: rtl/im_axi_read_slave_pkg.sv
// Shared AXI definitions: bus width macros, read-slave state encoding,
// response codes and burst types.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package im_axi_read_slave_pkg;
    localparam int AXI_IDS_BITS  = `AXI_IDS_BITS;
    localparam int AXI_ADDR_BITS = `AXI_ADDR_BITS;
    localparam int AXI_LEN_BITS  = `AXI_LEN_BITS;
    localparam int AXI_SIZE_BITS = `AXI_SIZE_BITS;
    localparam int AXI_DATA_BITS = `AXI_DATA_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [AXI_SIZE_BITS-1:0] SIZE_4B = 3'b010;
endpackage

// File: rtl/im_axi_read_slave_burst_addr_gen.sv
// Next-beat byte address for 4-byte beats under FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
    import im_axi_read_slave_pkg::*;
(
    input  logic [AXI_ADDR_BITS-1:0] i_addr,
    input  logic [AXI_LEN_BITS-1:0]  i_len,
    input  logic [1:0]               i_burst,
    output logic [AXI_ADDR_BITS-1:0] o_next_addr
);
    logic [AXI_ADDR_BITS-1:0] w_incr;
    logic [AXI_ADDR_BITS-1:0] w_mask;

    assign w_incr = i_addr + AXI_ADDR_BITS'(4);
    // Wrap window is (LEN+1) beats of 4 bytes; mask selects the offset inside it.
    assign w_mask = ((AXI_ADDR_BITS'(i_len) + AXI_ADDR_BITS'(1)) << 2) - AXI_ADDR_BITS'(1);

    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            BURST_INCR: o_next_addr = w_incr;
            BURST_WRAP: o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
            default:    o_next_addr = i_addr;
        endcase
    end
endmodule

// File: rtl/im_axi_read_slave.sv
// Single-outstanding AXI read slave in front of a one-cycle-latency word memory.
// Each beat is a FETCH (memory read) followed by a SEND (R channel hold).
module im_axi_read_slave
    import im_axi_read_slave_pkg::*;
#(
    parameter int  MEM_WORDS = 16384,
    localparam int MAW       = $clog2(MEM_WORDS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    output logic [AXI_IDS_BITS-1:0]  RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    output logic                     mem_cs,
    output logic [MAW-1:0]           mem_addr,
    input  logic [31:0]              mem_dout
);
    rd_state_e                r_state;
    logic [AXI_ADDR_BITS-1:0] r_addr;
    logic [AXI_LEN_BITS-1:0]  r_len;
    logic [AXI_LEN_BITS-1:0]  r_cnt;
    logic [1:0]               r_burst;
    logic                     r_err;
    logic                     r_pend;
    logic [1:0]               r_resp;

    logic [AXI_ADDR_BITS-1:0] w_next_addr;
    logic [AXI_ADDR_BITS-1:0] w_fetch_addr;
    logic [AXI_ADDR_BITS-3:0] w_fetch_word;
    logic                     w_ar_hs;
    logic                     w_r_hs;
    logic                     w_ar_illegal;
    logic                     w_fetch_err;
    logic                     w_fetch_oor;
    logic [1:0]               w_fetch_resp;

    axi_burst_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    assign w_ar_hs      = ARVALID_S && ARREADY_S;
    assign w_r_hs       = RVALID_S && RREADY_S;
    assign w_ar_illegal = (ARSIZE_S != SIZE_4B) || (ARBURST_S == BURST_RSVD);

    // The beat about to be fetched: first beat straight from AR, later beats from the address generator.
    assign w_fetch_addr = (r_state == S_IDLE) ? ARADDR_S : w_next_addr;
    assign w_fetch_err  = (r_state == S_IDLE) ? w_ar_illegal : r_err;
    assign w_fetch_word = w_fetch_addr[AXI_ADDR_BITS-1:2];
    assign w_fetch_oor  = w_fetch_word >= (AXI_ADDR_BITS-2)'(MEM_WORDS);
    assign w_fetch_resp = w_fetch_err ? RESP_SLVERR :
                          w_fetch_oor ? RESP_DECERR : RESP_OKAY;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            ARREADY_S <= 1'b0;
            RVALID_S  <= 1'b0;
            RLAST_S   <= 1'b0;
            RDATA_S   <= '0;
            RID_S     <= '0;
            RRESP_S   <= RESP_OKAY;
            mem_cs    <= 1'b0;
            mem_addr  <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_pend    <= 1'b0;
            r_resp    <= RESP_OKAY;
        end else begin
            mem_cs <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        ARREADY_S <= 1'b0;
                        RID_S     <= ARID_S;
                        r_addr    <= ARADDR_S;
                        r_len     <= ARLEN_S;
                        r_burst   <= ARBURST_S;
                        r_err     <= w_ar_illegal;
                        r_cnt     <= '0;
                        mem_cs    <= (w_fetch_resp == RESP_OKAY);
                        mem_addr  <= w_fetch_addr[MAW+1:2];
                        r_resp    <= w_fetch_resp;
                        r_state   <= S_FETCH;
                    end else begin
                        ARREADY_S <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_pend  <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    // First SEND cycle waits for mem_dout; the beat is presented from the next edge on.
                    if (r_pend) begin
                        r_pend   <= 1'b0;
                        RVALID_S <= 1'b1;
                        RRESP_S  <= r_resp;
                        RDATA_S  <= (r_resp == RESP_OKAY) ? mem_dout : '0;
                        RLAST_S  <= (r_cnt == r_len);
                    end else if (w_r_hs) begin
                        RVALID_S <= 1'b0;
                        RLAST_S  <= 1'b0;
                        if (RLAST_S) begin
                            ARREADY_S <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_cnt    <= r_cnt + 1'b1;
                            r_addr   <= w_next_addr;
                            mem_cs   <= (w_fetch_resp == RESP_OKAY);
                            mem_addr <= w_fetch_addr[MAW+1:2];
                            r_resp   <= w_fetch_resp;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
